// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the pins, frames and checks 11-bit packets,
// and keeps an 8-bit held-button map from make/break scancodes (E0/F0 prefixes).
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kb_clk,
    input  logic        kb_in_serial,
    output logic [7:0]  key_mux,
    output logic [10:0] kb_data,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ((^{data, par}) == 1'b1);
    endfunction

    // Returns {hit, bit index} for a key code in the given prefix context.
    function automatic logic [3:0] key_lookup(input logic ext, input logic [7:0] code);
        logic [3:0] r;
        r = 4'b0000;
        if (ext) begin
            case (code)
                8'h75:   r = 4'b1000;
                8'h72:   r = 4'b1001;
                8'h6B:   r = 4'b1010;
                8'h74:   r = 4'b1011;
                default: r = 4'b0000;
            endcase
        end else begin
            case (code)
                8'h22:   r = 4'b1100;
                8'h1A:   r = 4'b1101;
                8'h5A:   r = 4'b1110;
                8'h29:   r = 4'b1111;
                default: r = 4'b0000;
            endcase
        end
        return r;
    endfunction

    logic            kb_clk_meta_r, kb_clk_sync_r, kb_clk_prev_r;
    logic            kb_dat_meta_r, kb_dat_sync_r;
    logic            fall_r, bit_r;
    state_t          state_r, state_s;
    logic [3:0]      bit_cnt_r, bit_cnt_s;
    logic [TO_W-1:0] to_cnt_r, to_cnt_s;
    logic [10:0]     shift_r, shift_s;
    logic [10:0]     kb_data_r, kb_data_s;
    logic [7:0]      key_mux_r, key_mux_s;
    logic            ext_r, ext_s, brk_r, brk_s;
    logic            frame_valid_r, frame_valid_s;
    logic            frame_err_r, frame_err_s;
    logic [7:0]      code_s;
    logic            frame_ok_s;
    logic [3:0]      lookup_s;

    assign code_s     = shift_r[8:1];
    assign frame_ok_s = ~shift_r[0] & shift_r[10] & odd_parity_ok(shift_r[8:1], shift_r[9]);
    assign lookup_s   = key_lookup(ext_r, code_s);

    // Pin synchronisers; idle-high reset values avoid a phantom edge after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kb_clk_meta_r <= 1'b1;
            kb_clk_sync_r <= 1'b1;
            kb_clk_prev_r <= 1'b1;
            kb_dat_meta_r <= 1'b1;
            kb_dat_sync_r <= 1'b1;
            fall_r        <= 1'b0;
            bit_r         <= 1'b1;
        end else begin
            kb_clk_meta_r <= kb_clk;
            kb_clk_sync_r <= kb_clk_meta_r;
            kb_clk_prev_r <= kb_clk_sync_r;
            kb_dat_meta_r <= kb_in_serial;
            kb_dat_sync_r <= kb_dat_meta_r;
            fall_r        <= kb_clk_prev_r & ~kb_clk_sync_r;
            bit_r         <= kb_dat_sync_r;
        end
    end

    // Frame FSM next-state, timeout, and scancode/held-map update.
    always_comb begin
        state_s       = state_r;
        bit_cnt_s     = bit_cnt_r;
        to_cnt_s      = to_cnt_r;
        shift_s       = shift_r;
        kb_data_s     = kb_data_r;
        key_mux_s     = key_mux_r;
        ext_s         = ext_r;
        brk_s         = brk_r;
        frame_valid_s = 1'b0;
        frame_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                to_cnt_s = '0;
                if (fall_r && !bit_r) begin
                    shift_s   = {bit_r, shift_r[10:1]};
                    bit_cnt_s = 4'd0;
                    state_s   = ST_RECV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (fall_r) begin
                    shift_s   = {bit_r, shift_r[10:1]};
                    to_cnt_s  = '0;
                    bit_cnt_s = bit_cnt_r + 4'd1;
                    // Start bit came in from IDLE, so the tenth bit here is the stop bit.
                    if (bit_cnt_r == 4'd9) begin
                        state_s = ST_CHECK;
                    end else begin
                        state_s = ST_RECV;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    frame_err_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            ST_CHECK: begin
                state_s = ST_IDLE;
                if (frame_ok_s) begin
                    kb_data_s     = shift_r;
                    frame_valid_s = 1'b1;
                    if (code_s == 8'hE0) begin
                        ext_s = 1'b1;
                    end else if (code_s == 8'hF0) begin
                        brk_s = 1'b1;
                    end else begin
                        if (lookup_s[3]) begin
                            key_mux_s[lookup_s[2:0]] = ~brk_r;
                        end else begin
                            key_mux_s = key_mux_r;
                        end
                        ext_s = 1'b0;
                        brk_s = 1'b0;
                    end
                end else begin
                    frame_err_s = 1'b1;
                    ext_s       = 1'b0;
                    brk_s       = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= 4'd0;
            to_cnt_r      <= '0;
            shift_r       <= 11'd0;
            kb_data_r     <= 11'd0;
            key_mux_r     <= 8'd0;
            ext_r         <= 1'b0;
            brk_r         <= 1'b0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            bit_cnt_r     <= bit_cnt_s;
            to_cnt_r      <= to_cnt_s;
            shift_r       <= shift_s;
            kb_data_r     <= kb_data_s;
            key_mux_r     <= key_mux_s;
            ext_r         <= ext_s;
            brk_r         <= brk_s;
            frame_valid_r <= frame_valid_s;
            frame_err_r   <= frame_err_s;
        end
    end

    assign key_mux     = key_mux_r;
    assign kb_data     = kb_data_r;
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: scripted vector table, timeout and reset corner cases,
// then random scancode streams checked against a prefix/keymap reference model.
module tb_ps2_key_decoder;

    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kb_clk;
    logic        kb_in_serial;
    logic [7:0]  key_mux;
    logic [10:0] kb_data;
    logic        frame_valid;
    logic        frame_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(200)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kb_clk       (kb_clk),
        .kb_in_serial (kb_in_serial),
        .key_mux      (key_mux),
        .kb_data      (kb_data),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int cyc = 0;
    int fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) valid_cnt <= valid_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
        if (frame_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    // Reference model: held map, pending prefixes, last good frame.
    logic [7:0]  m_held;
    logic        m_ext;
    logic        m_brk;
    logic [10:0] m_kb;
    logic [8:0]  keymap [8];

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic [7:0] exp_mux;
    } vec_t;
    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] data, input logic bad_par,
                                               input logic bad_stop);
        logic par;
        par = (~^data) ^ bad_par;
        return {~bad_stop, par, data, 1'b0};
    endfunction

    task automatic model_reset();
        m_held = 8'h00;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_kb   = 11'h000;
    endtask

    task automatic model_frame(input logic [10:0] f);
        logic [7:0] code;
        int ones;
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(f[i]);
        if (f[0] != 1'b0 || f[10] != 1'b1 || (ones % 2) != 1) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            m_kb = f;
            code = f[8:1];
            if (code == 8'hE0) m_ext = 1'b1;
            else if (code == 8'hF0) m_brk = 1'b1;
            else begin
                for (int b = 0; b < 8; b++)
                    if (keymap[b] == {m_ext, code}) m_held[b] = !m_brk;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        kb_in_serial = b;
        repeat (HALF / 2) @(negedge clk);
        kb_clk = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        kb_clk = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        kb_in_serial = 1'b1;
    endtask

    task automatic do_frame(input logic [10:0] f, input string name);
        int vc, ec;
        logic good;
        vc = valid_cnt;
        ec = err_cnt;
        good = (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
        model_frame(f);
        send_bits(f, 11);
        repeat (5) @(negedge clk);
        check({name, ".valid_pulses"}, valid_cnt - vc, good ? 1 : 0);
        check({name, ".err_pulses"}, err_cnt - ec, good ? 0 : 1);
        check({name, ".key_mux"}, {24'd0, key_mux}, {24'd0, m_held});
        check({name, ".kb_data"}, {21'd0, kb_data}, {21'd0, m_kb});
    endtask

    initial begin
        logic [7:0] pool [12];
        logic [7:0] code;
        int ec, vc, delta, k;

        keymap[0] = {1'b1, 8'h75}; keymap[1] = {1'b1, 8'h72};
        keymap[2] = {1'b1, 8'h6B}; keymap[3] = {1'b1, 8'h74};
        keymap[4] = {1'b0, 8'h22}; keymap[5] = {1'b0, 8'h1A};
        keymap[6] = {1'b0, 8'h5A}; keymap[7] = {1'b0, 8'h29};

        vecs[0]  = '{8'h22, 1'b0, 1'b0, 8'h10};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 8'h10};
        vecs[2]  = '{8'h22, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{8'h75, 1'b0, 1'b0, 8'h01};
        vecs[5]  = '{8'h5A, 1'b0, 1'b0, 8'h41};
        vecs[6]  = '{8'hE0, 1'b0, 1'b0, 8'h41};
        vecs[7]  = '{8'hF0, 1'b0, 1'b0, 8'h41};
        vecs[8]  = '{8'h75, 1'b0, 1'b0, 8'h40};
        vecs[9]  = '{8'h1A, 1'b1, 1'b0, 8'h40};
        vecs[10] = '{8'h1A, 1'b0, 1'b0, 8'h60};
        vecs[11] = '{8'hF0, 1'b0, 1'b1, 8'h60};
        vecs[12] = '{8'h1A, 1'b0, 1'b0, 8'h60};
        vecs[13] = '{8'hF0, 1'b0, 1'b0, 8'h60};
        vecs[14] = '{8'hE0, 1'b0, 1'b0, 8'h60};
        vecs[15] = '{8'h5A, 1'b0, 1'b0, 8'h60};
        vecs[16] = '{8'hF0, 1'b0, 1'b0, 8'h60};
        vecs[17] = '{8'h5A, 1'b0, 1'b0, 8'h20};

        pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h75;  pool[3] = 8'h72;
        pool[4] = 8'h6B; pool[5] = 8'h74; pool[6] = 8'h22;  pool[7] = 8'h1A;
        pool[8] = 8'h5A; pool[9] = 8'h29; pool[10] = 8'hF0; pool[11] = 8'hE0;

        rst_n = 1'b0;
        kb_clk = 1'b1;
        kb_in_serial = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset.key_mux", {24'd0, key_mux}, 32'd0);
        check("reset.kb_data", {21'd0, kb_data}, 32'd0);
        check("reset.pulses", {30'd0, frame_valid, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Scripted table: make/break, extended, prefix ordering, parity and stop errors.
        for (int i = 0; i < 18; i++) begin
            do_frame(make_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop),
                     $sformatf("vec%0d", i));
            check($sformatf("vec%0d.table_mux", i), {24'd0, key_mux}, {24'd0, vecs[i].exp_mux});
        end
        check("make_x.kb_data_literal", 32'h644, {21'd0, make_frame(8'h22, 1'b0, 1'b0)});

        // Timeout after 5 bits, then a good Space frame.
        ec = err_cnt;
        vc = valid_cnt;
        send_bits(make_frame(8'h29, 1'b0, 1'b0), 5);
        k = 0;
        while (!frame_err && k < 400) begin
            @(negedge clk);
            k++;
        end
        delta = cyc - fall_cyc;
        check("timeout.latency_in_window", {31'd0, (delta >= 198 && delta <= 210)}, 32'd1);
        repeat (3) @(negedge clk);
        check("timeout.err_pulses", err_cnt - ec, 1);
        check("timeout.valid_pulses", valid_cnt - vc, 0);
        do_frame(make_frame(8'h29, 1'b0, 1'b0), "after_timeout");
        check("after_timeout.bit7", {31'd0, key_mux[7]}, 32'd1);

        // Build key_mux = 0x10, then reset in the middle of a frame.
        do_frame(make_frame(8'hF0, 1'b0, 1'b0), "prep0");
        do_frame(make_frame(8'h1A, 1'b0, 1'b0), "prep1");
        do_frame(make_frame(8'hF0, 1'b0, 1'b0), "prep2");
        do_frame(make_frame(8'h29, 1'b0, 1'b0), "prep3");
        do_frame(make_frame(8'h22, 1'b0, 1'b0), "prep4");
        check("prep.key_mux", {24'd0, key_mux}, 32'h10);
        send_bits(make_frame(8'h1A, 1'b0, 1'b0), 6);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("midreset.key_mux", {24'd0, key_mux}, 32'd0);
        check("midreset.kb_data", {21'd0, kb_data}, 32'd0);
        check("midreset.pulses", {30'd0, frame_valid, frame_err}, 32'd0);
        repeat (5) @(negedge clk);
        do_frame(make_frame(8'h22, 1'b0, 1'b0), "after_reset");
        check("after_reset.key_mux", {24'd0, key_mux}, 32'h10);

        // Random scancode stream with occasional corrupted frames.
        for (int n = 0; n < 50; n++) begin
            k = int'($urandom_range(0, 13));
            if (k < 12) code = pool[k];
            else code = 8'($urandom_range(0, 255));
            do_frame(make_frame(code, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0)),
                     $sformatf("rnd%0d", n));
        end

        check("never_valid_and_err", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
